// File: rtl/data_mem.sv
// data_mem: single-port word-addressed data memory for a core.
//
// After reset the array is self-cleared to zero, one word per cycle, for
// 2^A_SIZE cycles. While clearing, busy is high and any access from the core
// is dropped and latched into the sticky err flag. Once ready, reads have a
// one-cycle latency with a rd_valid pulse. A simultaneous read and write to
// the same word returns the new write data (write-first).
//
// Ports:
//   clk       single clock, rising edge
//   rst       synchronous reset, active-low
//   read      read request, sampled on the clock edge
//   write     write request, sampled on the clock edge
//   address   word address of the access
//   data_out  write data from the core
//   data_in   registered read data to the core
//   rd_valid  one-cycle pulse, data_in holds a fresh read result
//   busy      high while the array is being cleared
//   err       sticky, an access was attempted while busy
//   rd_cnt    saturating count of accepted reads
//   wr_cnt    saturating count of accepted writes

module data_mem #(
  parameter int A_SIZE = 10,
  parameter int D_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [A_SIZE-1:0] address,
  input  logic [D_SIZE-1:0] data_out,
  output logic [D_SIZE-1:0] data_in,
  output logic              rd_valid,
  output logic              busy,
  output logic              err,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
);

  localparam int DEPTH = 1 << A_SIZE;

  localparam logic CLEAR = 1'b0;
  localparam logic READY = 1'b1;

  logic              state;
  logic [A_SIZE-1:0] clr_ptr;

  logic [D_SIZE-1:0] mem [DEPTH];

  logic              mem_we;
  logic [A_SIZE-1:0] mem_addr;
  logic [D_SIZE-1:0] mem_wdata;

  function automatic logic [15:0] sat_inc(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  assign busy = (state == CLEAR);

  // Array write port is shared between the clear sweep and core writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = address;
    mem_wdata = data_out;
    if (rst) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = clr_ptr;
        mem_wdata = '0;
      end else begin
        mem_we = write;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Control and registered read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= CLEAR;
      clr_ptr  <= '0;
      data_in  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      rd_cnt   <= 16'd0;
      wr_cnt   <= 16'd0;
    end else if (state == CLEAR) begin
      clr_ptr  <= clr_ptr + 1'b1;
      rd_valid <= 1'b0;
      // Leave CLEAR on the same edge that zeroes the last word.
      if (clr_ptr == '1) begin
        state <= READY;
      end
      if (read || write) begin
        err <= 1'b1;
      end
    end else begin
      rd_valid <= read;
      if (read) begin
        // Write-first: a same-cycle write bypasses the array.
        data_in <= write ? data_out : mem[address];
        rd_cnt  <= sat_inc(rd_cnt);
      end
      if (write) begin
        wr_cnt <= sat_inc(wr_cnt);
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

  logic        clk;
  logic        rst;
  logic        read;
  logic        write;
  logic [9:0]  address;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        rd_valid;
  logic        busy;
  logic        err;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  int checks = 0;
  int errors = 0;

  data_mem #(.A_SIZE(10), .D_SIZE(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .read     (read),
    .write    (write),
    .address  (address),
    .data_out (data_out),
    .data_in  (data_in),
    .rd_valid (rd_valid),
    .busy     (busy),
    .err      (err),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; read = 1'b0; write = 1'b0; address = '0; data_out = '0;
    tick();
    checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b rd_valid=%b err=%b, want 1 0 0", busy, rd_valid, err);
    end
    checks++;
    if (data_in !== 32'h0 || rd_cnt !== 16'h0 || wr_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: data_in=%h rd_cnt=%h wr_cnt=%h, want 0 0 0", data_in, rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_clear_time();
    int n = 0;
    rst = 1'b1;
    while (busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n != 1024 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_time: busy cycles=%0d busy=%b, want 1024 0", n, busy);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL clear_err: err=%b, want 0", err);
    end
  endtask

  task automatic test_read_top();
    read = 1'b1; address = 10'h3FF;
    tick();
    read = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || data_in !== 32'h0 || rd_cnt !== 16'd1) begin
      errors++;
      $display("FAIL read_top: rd_valid=%b data_in=%h rd_cnt=%0d, want 1 0 1", rd_valid, data_in, rd_cnt);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_pulse: rd_valid=%b, want 0", rd_valid);
    end
  endtask

  task automatic test_write_read();
    write = 1'b1; address = 10'd7; data_out = 32'h0000000D;
    tick();
    write = 1'b0; read = 1'b1; data_out = 32'hDEADBEEF;
    tick();
    read = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || data_in !== 32'h0000000D || wr_cnt !== 16'd1 || rd_cnt !== 16'd2) begin
      errors++;
      $display("FAIL write_read: rd_valid=%b data_in=%h wr_cnt=%0d rd_cnt=%0d, want 1 0000000d 1 2",
               rd_valid, data_in, wr_cnt, rd_cnt);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || data_in !== 32'h0000000D) begin
      errors++;
      $display("FAIL read_hold: rd_valid=%b data_in=%h, want 0 0000000d", rd_valid, data_in);
    end
  endtask

  task automatic test_rw_same();
    read = 1'b1; write = 1'b1; address = 10'd1; data_out = 32'hA5A5A5A5;
    tick();
    write = 1'b0; data_out = 32'h0;
    checks++;
    if (data_in !== 32'hA5A5A5A5 || rd_valid !== 1'b1 || rd_cnt !== 16'd3 || wr_cnt !== 16'd2) begin
      errors++;
      $display("FAIL rw_same: data_in=%h rd_valid=%b rd_cnt=%0d wr_cnt=%0d, want a5a5a5a5 1 3 2",
               data_in, rd_valid, rd_cnt, wr_cnt);
    end
    // read stays high: confirm the word really landed in the array
    tick();
    read = 1'b0;
    checks++;
    if (data_in !== 32'hA5A5A5A5 || rd_cnt !== 16'd4) begin
      errors++;
      $display("FAIL rw_stored: data_in=%h rd_cnt=%0d, want a5a5a5a5 4", data_in, rd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    read = 1'b1; address = 10'd7;
    tick();
    address = 10'd1;
    checks++;
    if (data_in !== 32'h0000000D || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: data_in=%h rd_valid=%b, want 0000000d 1", data_in, rd_valid);
    end
    tick();
    read = 1'b0;
    checks++;
    if (data_in !== 32'hA5A5A5A5 || rd_valid !== 1'b1 || rd_cnt !== 16'd6) begin
      errors++;
      $display("FAIL b2b_second: data_in=%h rd_valid=%b rd_cnt=%0d, want a5a5a5a5 1 6", data_in, rd_valid, rd_cnt);
    end
    tick();
  endtask

  task automatic test_err_during_clear();
    int n = 0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: err=%b, want 0", err);
    end
    repeat (4) tick();
    // cycle 5: the sweep is at word 4, so word 1 is already cleared
    write = 1'b1; address = 10'd1; data_out = 32'hFFFFFFFF;
    tick();
    write = 1'b0;
    n = 5;
    checks++;
    if (err !== 1'b1 || wr_cnt !== 16'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_set: err=%b wr_cnt=%0d rd_valid=%b, want 1 0 0", err, wr_cnt, rd_valid);
    end
    while (busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n != 1024 || err !== 1'b1 || wr_cnt !== 16'd0) begin
      errors++;
      $display("FAIL err_sticky: clear cycles=%0d err=%b wr_cnt=%0d, want 1024 1 0", n, err, wr_cnt);
    end
    read = 1'b1; address = 10'd1;
    tick();
    read = 1'b0;
    checks++;
    if (data_in !== 32'h0 || rd_cnt !== 16'd1) begin
      errors++;
      $display("FAIL err_target: data_in=%h rd_cnt=%0d, want 0 1", data_in, rd_cnt);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    write = 1'b1; address = 10'd9; data_out = 32'h12345678;
    tick();
    write = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (500) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy=%b, want 1", busy);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    while (busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n != 1024) begin
      errors++;
      $display("FAIL mid_restart: clear cycles=%0d, want 1024", n);
    end
    read = 1'b1; address = 10'd9;
    tick();
    read = 1'b0;
    checks++;
    if (data_in !== 32'h0 || rd_valid !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_cleared: data_in=%h rd_valid=%b err=%b, want 0 1 0", data_in, rd_valid, err);
    end
  endtask

  task automatic test_reset_inflight();
    // load a nonzero word, then a read that collides with reset
    write = 1'b1; address = 10'd3; data_out = 32'hCAFEF00D;
    tick();
    write = 1'b0; read = 1'b1; rst = 1'b0;
    tick();
    read = 1'b0; rst = 1'b1;
    checks++;
    if (rd_valid !== 1'b0 || data_in !== 32'h0 || busy !== 1'b1 || rd_cnt !== 16'd0) begin
      errors++;
      $display("FAIL inflight: rd_valid=%b data_in=%h busy=%b rd_cnt=%0d, want 0 0 1 0",
               rd_valid, data_in, busy, rd_cnt);
    end
  endtask

  task automatic test_saturation();
    int n = 1;
    while (busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    read = 1'b1; write = 1'b1; address = 10'd0; data_out = 32'h0;
    repeat (65534) tick();
    checks++;
    if (rd_cnt !== 16'hFFFE || wr_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_near: rd_cnt=%h wr_cnt=%h, want fffe fffe", rd_cnt, wr_cnt);
    end
    tick();
    checks++;
    if (rd_cnt !== 16'hFFFF || wr_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach: rd_cnt=%h wr_cnt=%h, want ffff ffff", rd_cnt, wr_cnt);
    end
    tick();
    read = 1'b0; write = 1'b0;
    checks++;
    if (rd_cnt !== 16'hFFFF || wr_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: rd_cnt=%h wr_cnt=%h, want ffff ffff", rd_cnt, wr_cnt);
    end
  endtask

  initial begin
    rst = 1'b0; read = 1'b0; write = 1'b0; address = '0; data_out = '0;
    test_reset();
    test_clear_time();
    test_read_top();
    test_write_read();
    test_rw_same();
    test_back_to_back();
    test_err_during_clear();
    test_reset_mid_clear();
    test_reset_inflight();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter A_SIZE, default 10, address width in bits; depth = 2^A_SIZE words.
REQ-002 SHALL have parameter D_SIZE, default 32, data word width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port read  input  1  read request from core, sampled on the clk edge.
REQ-006 SHALL have port write  input  1  write request from core, sampled on the clk edge.
REQ-007 SHALL have port address  input  A_SIZE  word address of the access.
REQ-008 SHALL have port data_out  input  D_SIZE  write data from core.
REQ-009 SHALL have port data_in  output  D_SIZE  registered read data to core.
REQ-010 SHALL have port rd_valid  output  1  one-cycle pulse, data_in holds a fresh read result.
REQ-011 SHALL have port busy  output  1  high while the memory self-clears after reset.
REQ-012 SHALL have port err  output  1  sticky flag, access attempted while busy.
REQ-013 SHALL have port rd_cnt  output  16  saturating count of accepted reads.
REQ-014 SHALL have port wr_cnt  output  16  saturating count of accepted writes.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR, READY.
REQ-016 SHALL enter CLEAR on reset with internal clear pointer = 0.
REQ-017 In CLEAR, each cycle SHALL write 0 to mem[clear pointer] and increment the pointer.
REQ-018 SHALL transition CLEAR -> READY on the cycle the pointer = 2^A_SIZE-1 is written; CLEAR lasts exactly 2^A_SIZE cycles.
REQ-019 busy SHALL be 1 in CLEAR and 0 in READY, decoded from state register.
REQ-020 In CLEAR, read/write SHALL be ignored (no array write, no rd_valid, no count change) and SHALL set err if either is 1.
REQ-021 In READY, write=1 SHALL store data_out into mem[address] at the clock edge.
REQ-022 In READY, read=1 SHALL load data_in with mem[address] at the clock edge and assert rd_valid for exactly the following cycle; read latency = 1 cycle.
REQ-023 Read and write both 1 in READY SHALL perform the write and return the newly written data_out on data_in (write-first); both counters increment.
REQ-024 Read in cycle N+1 of an address written in cycle N SHALL return the cycle-N data.
REQ-025 With read=0, data_in SHALL hold its last value; rd_valid = 0.
REQ-026 rd_cnt/wr_cnt SHALL increment by 1 per accepted read/write and saturate at 16'hFFFF.
REQ-027 err SHALL remain 1 once set until reset.
REQ-028 Address is always in range (full 2^A_SIZE decode); no wrap logic beyond A_SIZE bits.

Reset
REQ-029 On rst=0 at a clock edge: state=CLEAR, clear pointer=0, data_in=0, rd_valid=0, busy=1, err=0, rd_cnt=0, wr_cnt=0.
REQ-030 Reset asserted mid-CLEAR SHALL restart clearing from address 0.
REQ-031 Reset asserted in READY SHALL abandon any in-flight read (no rd_valid next cycle) and re-clear the whole array.
REQ-032 Reset is synchronous only; rst changes without a clock edge SHALL have no effect.

Verification
REQ-033 Release rst, hold read/write 0 -> busy=1 for exactly 1024 cycles then 0; err=0.
REQ-034 After clear, read address 10'h3FF -> next cycle rd_valid=1, data_in=0, rd_cnt=1.
REQ-035 Write 32'h0000000D to address 7, then read address 7 next cycle -> data_in=32'h0000000D, rd_valid pulse one cycle, wr_cnt=1.
REQ-036 read=1 and write=1, address 1, data_out=32'hA5A5A5A5 -> next cycle data_in=32'hA5A5A5A5, rd_cnt and wr_cnt each +1.
REQ-037 write=1 during CLEAR (cycle 5 after release) -> err=1 and stays 1, wr_cnt=0, target address still 0 after clear.
REQ-038 Pulse rst low at cycle 500 of CLEAR -> busy stays 1 for a further 1024 cycles; previously written data reads back 0.
